// File: rtl/stage_lighting_pkg.sv
// Shared encodings for the stage lighting controller: mode and spotlight
// states, spotlight one-hot output codes and small decode helpers.
package stage_lighting_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        PLAY    = 3'd1,
        MUSIC   = 3'd2,
        SPEAKER = 3'd3,
        HOUSE   = 3'd4
    } mode_t;

    typedef enum logic [1:0] {
        LEFT   = 2'd0,
        CENTER = 2'd1,
        RIGHT  = 2'd2
    } spot_t;

    localparam logic [2:0] SPO_L   = 3'b100;
    localparam logic [2:0] SPO_C   = 3'b010;
    localparam logic [2:0] SPO_R   = 3'b001;
    localparam logic [2:0] SPO_OFF = 3'b000;

    // OFF doubles as "no request": zero or several switches, or system disabled.
    function automatic mode_t decode_request(input logic sys_en, input logic pm,
                                             input logic mm, input logic sm,
                                             input logic hm);
        mode_t req;
        req = OFF;
        if (sys_en) begin
            case ({pm, mm, sm, hm})
                4'b1000: req = PLAY;
                4'b0100: req = MUSIC;
                4'b0010: req = SPEAKER;
                4'b0001: req = HOUSE;
                default: req = OFF;
            endcase
        end
        return req;
    endfunction

    function automatic logic [2:0] spot_onehot(input spot_t s);
        logic [2:0] code;
        case (s)
            LEFT:    code = SPO_L;
            CENTER:  code = SPO_C;
            RIGHT:   code = SPO_R;
            default: code = SPO_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/spotlight_ctrl.sv
// Three-position spotlight FSM driven by active-low touch pads.
// SPOT_DIRECT_JUMP_EN: jump straight to the target instead of stepping via CENTER.
module spotlight_ctrl
    import stage_lighting_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       SEN,
    input  logic       TL,
    input  logic       TC,
    input  logic       TR,
    output logic [2:0] SPO
);

    spot_t spot_reg;
    spot_t spot_next;
    spot_t target;
    logic  has_target;

    // Center pad wins over left, left over right.
    always_comb begin
        has_target = 1'b1;
        target     = CENTER;
        if (!TC) begin
            target = CENTER;
        end else if (!TL) begin
            target = LEFT;
        end else if (!TR) begin
            target = RIGHT;
        end else begin
            has_target = 1'b0;
        end
    end

    always_comb begin
        spot_next = spot_reg;
        if (!SEN) begin
            spot_next = CENTER;
        end else if (has_target && (target != spot_reg)) begin
`ifdef SPOT_DIRECT_JUMP_EN
            spot_next = target;
`else
            // Any move away from an edge lands on CENTER first.
            spot_next = (spot_reg == CENTER) ? target : CENTER;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spot_reg <= CENTER;
        end else begin
            spot_reg <= spot_next;
        end
    end

    assign SPO = SEN ? spot_onehot(spot_reg) : SPO_OFF;

endmodule

// File: rtl/stage_lighting_ctrl.sv
// Stage panel controller: mode FSM for AV/house lights plus spotlight FSM.
// Optional build macro SPOT_DIRECT_JUMP_EN (see spotlight_ctrl).
module stage_lighting_ctrl
    import stage_lighting_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       SysEN,
    input  logic       PM,
    input  logic       MM,
    input  logic       SM,
    input  logic       HM,
    input  logic       TL,
    input  logic       TC,
    input  logic       TR,
    output logic       V,
    output logic       HL,
    output logic [2:0] SPO
);

    mode_t mode_reg;
    mode_t mode_next;
    mode_t req;
    logic  v_reg;
    logic  hl_reg;
    logic  sen_reg;

    always_comb begin
        req = decode_request(SysEN, PM, MM, SM, HM);
    end

    // Leaving an active mode always lands in OFF, so switching modes
    // costs one dark cycle.
    always_comb begin
        mode_next = mode_reg;
        if (mode_reg == OFF) begin
            mode_next = req;
        end else if (req != mode_reg) begin
            mode_next = OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_reg <= OFF;
            v_reg    <= 1'b0;
            hl_reg   <= 1'b0;
            sen_reg  <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            case (mode_next)
                PLAY: begin
                    v_reg   <= 1'b1;
                    hl_reg  <= 1'b0;
                    sen_reg <= 1'b1;
                end
                MUSIC: begin
                    v_reg   <= 1'b1;
                    hl_reg  <= 1'b0;
                    sen_reg <= 1'b0;
                end
                SPEAKER: begin
                    v_reg   <= 1'b1;
                    hl_reg  <= 1'b0;
                    sen_reg <= 1'b1;
                end
                HOUSE: begin
                    v_reg   <= 1'b0;
                    hl_reg  <= 1'b1;
                    sen_reg <= 1'b0;
                end
                default: begin
                    v_reg   <= 1'b0;
                    hl_reg  <= 1'b0;
                    sen_reg <= 1'b0;
                end
            endcase
        end
    end

    assign V  = v_reg;
    assign HL = hl_reg;

    spotlight_ctrl u_spot (
        .clk (clk),
        .rst (rst),
        .SEN (sen_reg),
        .TL  (TL),
        .TC  (TC),
        .TR  (TR),
        .SPO (SPO)
    );

endmodule

// File: tb/tb_stage_lighting_ctrl.sv
// Directed and randomized checks of stage_lighting_ctrl against a
// behavioural model of modes and spotlight position (-1 = L, 0 = C, +1 = R).
module tb_stage_lighting_ctrl;

    logic       clk;
    logic       rst;
    logic       SysEN, PM, MM, SM, HM, TL, TC, TR;
    logic       V, HL;
    logic [2:0] SPO;

    int compared = 0;
    int mismatched = 0;

    // Model state: 0 off, 1 play, 2 music, 3 speaker, 4 house
    int m_mode = 0;
    int m_pos  = 0;

    stage_lighting_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .SysEN (SysEN),
        .PM    (PM),
        .MM    (MM),
        .SM    (SM),
        .HM    (HM),
        .TL    (TL),
        .TC    (TC),
        .TR    (TR),
        .V     (V),
        .HL    (HL),
        .SPO   (SPO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int requested(input bit s, input bit p, input bit m,
                                     input bit k, input bit h);
        int n;
        n = int'(p) + int'(m) + int'(k) + int'(h);
        if (!s || n != 1) return 0;
        if (p) return 1;
        if (m) return 2;
        if (k) return 3;
        return 4;
    endfunction

    task automatic check(input string tag, input logic [2:0] observed,
                         input logic [2:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit m,
                        input bit k, input bit h, input bit l, input bit c,
                        input bit t, input string tag);
        bit lit;
        int q;
        int tgt;
        bit has;
        logic [2:0] exp_spo;
        rst = r; SysEN = s; PM = p; MM = m; SM = k; HM = h;
        TL = l; TC = c; TR = t;
        @(posedge clk);
        if (!r) begin
            m_mode = 0;
            m_pos  = 0;
        end else begin
            lit = (m_mode == 1 || m_mode == 3);
            has = 1'b1;
            tgt = 0;
            if (!c)      tgt = 0;
            else if (!l) tgt = -1;
            else if (!t) tgt = 1;
            else         has = 1'b0;
            if (!lit) begin
                m_pos = 0;
            end else if (has) begin
`ifdef SPOT_DIRECT_JUMP_EN
                m_pos = tgt;
`else
                if (tgt > m_pos) m_pos = m_pos + 1;
                else if (tgt < m_pos) m_pos = m_pos - 1;
`endif
            end
            q = requested(s, p, m, k, h);
            if (m_mode == 0) m_mode = q;
            else if (q != m_mode) m_mode = 0;
        end
        #1;
        exp_spo = 3'b000;
        if (m_mode == 1 || m_mode == 3)
            exp_spo = (m_pos < 0) ? 3'b100 : (m_pos == 0) ? 3'b010 : 3'b001;
        $display("%-10s rst=%b sys=%b sw=%b%b%b%b pads=%b%b%b -> V=%b HL=%b SPO=%b",
                 tag, r, s, p, m, k, h, l, c, t, V, HL, SPO);
        check({tag, ".V"},   {2'b00, V},  {2'b00, (m_mode >= 1 && m_mode <= 3) ? 1'b1 : 1'b0});
        check({tag, ".HL"},  {2'b00, HL}, {2'b00, (m_mode == 4) ? 1'b1 : 1'b0});
        check({tag, ".SPO"}, SPO, exp_spo);
    endtask

    initial begin
        bit s, p, m, k, h;
        bit [3:0] sw;
        // Reset with a valid request held
        step(0, 1, 0, 1, 0, 0, 1, 1, 1, "reset0");
        step(0, 1, 0, 1, 0, 0, 1, 1, 1, "reset1");
        step(1, 1, 0, 1, 0, 0, 1, 1, 1, "rel_mm");
        // Mode sequencing through OFF
        step(1, 1, 0, 0, 0, 1, 1, 1, 1, "to_hm_off");
        step(1, 1, 0, 0, 0, 1, 1, 1, 1, "house");
        step(1, 1, 0, 1, 0, 0, 1, 1, 1, "to_mm_off");
        step(1, 1, 0, 1, 0, 0, 1, 1, 1, "music");
        step(1, 1, 0, 0, 0, 0, 1, 1, 1, "all_zero");
        // Spotlight stepping in SPEAKER
        step(1, 1, 0, 0, 1, 0, 1, 1, 1, "speaker");
        step(1, 1, 0, 0, 1, 0, 0, 1, 1, "tl");
        step(1, 1, 0, 0, 1, 0, 1, 1, 0, "tr1");
        step(1, 1, 0, 0, 1, 0, 1, 1, 0, "tr2");
        step(1, 1, 0, 0, 1, 0, 1, 0, 1, "tc");
        // Several switches -> no request
        step(1, 1, 1, 1, 0, 0, 1, 1, 1, "multi1");
        step(1, 1, 1, 1, 0, 0, 1, 1, 1, "multi2");
        // Shutdown from PLAY at RIGHT
        step(1, 1, 1, 0, 0, 0, 1, 1, 1, "play");
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, "play_tr1");
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, "play_tr2");
        step(1, 0, 1, 0, 0, 0, 1, 1, 1, "sys_off");
        step(1, 1, 1, 0, 0, 0, 1, 1, 1, "reenable");
        // Pad priority from LEFT
        step(1, 1, 1, 0, 0, 0, 0, 1, 1, "go_left");
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, "all_pads");
        // Reset mid-operation
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, "pre_rst");
        step(0, 1, 1, 0, 0, 0, 1, 1, 0, "mid_rst");
        // Randomized: switches mostly held so modes persist long enough to steer
        s = 1; p = 0; m = 0; k = 1; h = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
                else sw = 4'(1 << $urandom_range(0, 3));
                {p, m, k, h} = sw;
            end
            s = ($urandom_range(0, 24) != 0);
            step(($urandom_range(0, 99) != 0), s, p, m, k, h,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) != 0),
                 ($urandom_range(0, 3) != 0), "rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
